// File: rtl/sent_tx_engine.sv
// rtl/sent_tx_engine.sv - SENT transmitter: config shadowing, frame FIFO, CRC4 and pulse timing FSM
// The in-flight frame keeps its FIFO slot until its last pulse ends, so occupancy counts it.
module sent_tx_engine #(
  parameter int CHANNEL_INDEX = 0,
  parameter int CLK_FREQ      = 100000000,
  parameter int FIFO_DEPTH    = 32,
  parameter int DATA_NIBBLES  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sent_config_vld,
  input  logic [7:0]  sent_config_channel,
  input  logic [7:0]  sent_ctick_len,
  input  logic [7:0]  sent_ltick_len,
  input  logic [1:0]  sent_pause_mode,
  input  logic [15:0] sent_pause_len,
  input  logic        sent_crc_mode,
  input  logic        sent_frame_vld,
  input  logic [31:0] sent_frame_data,
  output logic        sent,
  output logic        busy,
  output logic        fifo_full,
  output logic        frame_done,
  output logic        frame_drop
);
  localparam int DIV = CLK_FREQ / 1000000;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CHAN = 8'(CHANNEL_INDEX);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BASE_TICKS = 16'(56 + 12 * (DATA_NIBBLES + 2));
  localparam logic [63:0] CRC_TAB = {4'h5, 4'h8, 4'h2, 4'hF, 4'hB, 4'h6, 4'hC, 4'h1,
                                     4'h4, 4'h9, 4'h3, 4'hE, 4'hA, 4'h7, 4'hD, 4'h0};

  typedef enum logic [2:0] {IDLE, SYNC, STATUS, DATA, CRC, PAUSE} state_t;

  state_t      state;
  logic [27:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [7:0]  s_ctick, s_ltick, w_ctick, w_ltick;
  logic [1:0]  s_pmode, w_pmode;
  logic [15:0] s_plen, w_plen;
  logic        s_crc, w_crc;
  logic [27:0] frame;
  logic [2:0]  idx;
  logic [15:0] tick_cnt;
  logic [31:0] pre_cnt;
  logic        line_r, busy_r, done_r;

  logic        cfg_hit, wr_ok, tick, pulse_end, frame_end, start, pause_en;
  logic [7:0]  c_ctick, c_ltick, nib_sum;
  logic [1:0]  c_pmode;
  logic [15:0] c_plen, pulse_len, pause_ticks, frame_ticks;
  logic [3:0]  crc, data_nib;
  logic [4:0]  data_base;
  logic [27:0] next_head;
  logic [31:0] tick_clks;
  logic        unused_bits;

  assign unused_bits = ^sent_frame_data[31:28];

  assign cfg_hit = sent_config_vld && (sent_config_channel == CHAN);
  assign c_ctick = (sent_ctick_len < 8'd3) ? 8'd3 : (sent_ctick_len > 8'd90) ? 8'd90 : sent_ctick_len;
  assign c_ltick = (sent_ltick_len < 8'd4) ? 8'd4 : (sent_ltick_len > 8'd11) ? 8'd11 : sent_ltick_len;
  assign c_pmode = (sent_pause_mode == 2'd3) ? 2'd0 : sent_pause_mode;
  assign c_plen  = (c_pmode != 2'd1) ? sent_pause_len :
                   (sent_pause_len < 16'd12) ? 16'd12 :
                   (sent_pause_len > 16'd768) ? 16'd768 : sent_pause_len;

  assign wr_ok     = sent_frame_vld && (count != DEPTH);
  assign fifo_full = (count == DEPTH);

  always_comb begin
    crc = 4'd5;
    nib_sum = {4'd0, frame[27:24]};
    for (int k = 0; k < DATA_NIBBLES; k++) begin
      crc = CRC_TAB[{crc, 2'b00} +: 4] ^ frame[20-4*k +: 4];
      nib_sum = nib_sum + {4'd0, frame[20-4*k +: 4]};
    end
    if (w_crc) crc = CRC_TAB[{crc, 2'b00} +: 4];
  end

  // Constant-length mode pads the frame out, never shorter than the minimum 12-tick pause.
  assign frame_ticks = BASE_TICKS + {8'd0, nib_sum};
  assign pause_ticks = (w_pmode == 2'd1) ? w_plen :
                       ({1'b0, w_plen} < {1'b0, frame_ticks} + 17'd12) ? 16'd12 : w_plen - frame_ticks;
  assign pause_en    = (w_pmode == 2'd1) || (w_pmode == 2'd2);
  assign data_base   = 5'd20 - {idx, 2'b00};
  assign data_nib    = frame[data_base +: 4];

  always_comb begin
    pulse_len = 16'd56;
    case (state)
      STATUS:  pulse_len = 16'd12 + {12'd0, frame[27:24]};
      DATA:    pulse_len = 16'd12 + {12'd0, data_nib};
      CRC:     pulse_len = 16'd12 + {12'd0, crc};
      PAUSE:   pulse_len = pause_ticks;
      default: pulse_len = 16'd56;
    endcase
  end

  assign tick_clks = 32'(w_ctick) * 32'(DIV);
  assign tick      = (state != IDLE) && (pre_cnt == tick_clks - 32'd1);
  assign pulse_end = tick && (tick_cnt == pulse_len - 16'd1);
  assign frame_end = pulse_end && ((state == PAUSE) || (state == CRC && !pause_en));
  assign start     = ((state == IDLE) && (count != '0)) || (frame_end && (count > (AW+1)'(1)));
  assign next_head = (state == IDLE) ? mem[rd_ptr] : mem[rd_ptr + 1'b1];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= sent_frame_data[27:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= sent_frame_vld && !wr_ok;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (frame_end) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(frame_end);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ctick <= 8'd3;
      s_ltick <= 8'd5;
      s_pmode <= 2'd0;
      s_plen  <= 16'd12;
      s_crc   <= 1'b1;
    end else if (cfg_hit) begin
      s_ctick <= c_ctick;
      s_ltick <= c_ltick;
      s_pmode <= c_pmode;
      s_plen  <= c_plen;
      s_crc   <= sent_crc_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w_ctick  <= 8'd3;
      w_ltick  <= 8'd5;
      w_pmode  <= 2'd0;
      w_plen   <= 16'd12;
      w_crc    <= 1'b1;
      frame    <= '0;
      idx      <= '0;
      tick_cnt <= '0;
      pre_cnt  <= '0;
      line_r   <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      line_r <= !((state != IDLE) && (tick_cnt < {8'd0, w_ltick}));
      busy_r <= (state != IDLE);
      done_r <= frame_end;
      if (start) begin
        state    <= SYNC;
        frame    <= next_head;
        idx      <= '0;
        tick_cnt <= '0;
        pre_cnt  <= '0;
        w_ctick  <= cfg_hit ? c_ctick : s_ctick;
        w_ltick  <= cfg_hit ? c_ltick : s_ltick;
        w_pmode  <= cfg_hit ? c_pmode : s_pmode;
        w_plen   <= cfg_hit ? c_plen : s_plen;
        w_crc    <= cfg_hit ? sent_crc_mode : s_crc;
      end else if (state != IDLE) begin
        pre_cnt <= tick ? 32'd0 : pre_cnt + 32'd1;
        if (pulse_end) begin
          tick_cnt <= '0;
          case (state)
            SYNC:    state <= STATUS;
            STATUS:  state <= DATA;
            DATA: begin
              if (idx == 3'(DATA_NIBBLES - 1)) state <= CRC;
              else idx <= idx + 3'd1;
            end
            CRC:     state <= pause_en ? PAUSE : IDLE;
            default: state <= IDLE;
          endcase
        end else if (tick) begin
          tick_cnt <= tick_cnt + 16'd1;
        end
      end
    end
  end

  // Output retiming stage: sent/busy/frame_done share one alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sent       <= line_r;
      busy       <= busy_r;
      frame_done <= done_r;
    end
  end
endmodule

// File: tb/tb_sent_tx_engine.sv
// tb/tb_sent_tx_engine.sv - scoreboard bench for sent_tx_engine (2 MHz clock ratio, 4-deep FIFO)
module tb_sent_tx_engine;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sent_config_vld = 1'b0;
  logic [7:0]  sent_config_channel = '0;
  logic [7:0]  sent_ctick_len = '0;
  logic [7:0]  sent_ltick_len = '0;
  logic [1:0]  sent_pause_mode = '0;
  logic [15:0] sent_pause_len = '0;
  logic        sent_crc_mode = 1'b0;
  logic        sent_frame_vld = 1'b0;
  logic [31:0] sent_frame_data = '0;
  logic        sent, busy, fifo_full, frame_done, frame_drop;

  always #5 clk = ~clk;

  sent_tx_engine #(.CHANNEL_INDEX(3), .CLK_FREQ(2000000), .FIFO_DEPTH(4), .DATA_NIBBLES(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .sent_config_vld(sent_config_vld), .sent_config_channel(sent_config_channel),
    .sent_ctick_len(sent_ctick_len), .sent_ltick_len(sent_ltick_len),
    .sent_pause_mode(sent_pause_mode), .sent_pause_len(sent_pause_len),
    .sent_crc_mode(sent_crc_mode), .sent_frame_vld(sent_frame_vld),
    .sent_frame_data(sent_frame_data), .sent(sent), .busy(busy),
    .fifo_full(fifo_full), .frame_done(frame_done), .frame_drop(frame_drop)
  );

  typedef struct {int low; int per; int gap;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, drops = 0, falls = 0;
  logic prev_sent = 1'b1;
  bit   in_pulse = 1'b0;
  int   low_c = 0, per_c = 0, gap_c = 0, idle_c = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic close_pulse();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: low %0d period %0d with empty scoreboard", low_c, per_c);
    end else begin
      e = q.pop_front();
      check("pulse_low", low_c, e.low);
      check("pulse_period", per_c, e.per);
      if (e.gap >= 0) check("frame_gap", gap_c, e.gap);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse = 1'b0;
      prev_sent = 1'b1;
      idle_c = 0;
    end else begin
      if (frame_drop) drops++;
      if (prev_sent && !sent) begin
        if (in_pulse) close_pulse();
        in_pulse = 1'b1;
        low_c = 1;
        per_c = 1;
        gap_c = idle_c;
        falls++;
      end else if (in_pulse) begin
        per_c++;
        if (!sent) low_c++;
      end else begin
        idle_c++;
      end
      if (frame_done) begin
        if (in_pulse) close_pulse();
        in_pulse = 1'b0;
        idle_c = 0;
      end
      prev_sent = sent;
    end
  end

  // lens in ticks; crc is the hand-computed value for the frame and crc mode.
  task automatic push_frame(input logic [31:0] f, input int crc, input int ct, input int lt,
                            input int pause, input int gap, input int lim);
    int t, n;
    int lens[10];
    t = ct * DIV;
    lens[0] = 56;
    lens[1] = 12 + int'(f[27:24]);
    for (int k = 0; k < 6; k++) lens[2+k] = 12 + int'((f >> (20 - 4*k)) & 32'hF);
    lens[8] = 12 + crc;
    n = 9;
    if (pause > 0) begin
      lens[9] = pause;
      n = 10;
    end
    if (lim < n) n = lim;
    for (int i = 0; i < n; i++) q.push_back('{lt * t, lens[i] * t, (i == 0) ? gap : -1});
  endtask

  task automatic cfg(input logic [7:0] ch, input int ct, input int lt, input int pm,
                     input int pl, input int cm);
    @(negedge clk);
    sent_config_vld = 1'b1;
    sent_config_channel = ch;
    sent_ctick_len = 8'(ct);
    sent_ltick_len = 8'(lt);
    sent_pause_mode = 2'(pm);
    sent_pause_len = 16'(pl);
    sent_crc_mode = 1'(cm);
    @(negedge clk);
    sent_config_vld = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    sent_frame_vld = 1'b1;
    sent_frame_data = d;
    @(negedge clk);
    sent_frame_vld = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: timeout, %0d pulses outstanding busy %0d", name, q.size(), busy);
    end
  endtask

  logic [31:0] ov [5];
  int falls_snap;

  initial begin
    ov = '{32'h0, 32'h05123456, 32'hFAFFFFFF, 32'h0, 32'h05123456};
    repeat (3) @(negedge clk);
    check("reset_sent", sent, 1);
    check("reset_busy", busy, 0);
    check("reset_full", fifo_full, 0);
    check("reset_done", frame_done, 0);
    check("reset_drop", frame_drop, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default config, all-zero frame: CRC 5, sent falls 3 clk after the write edge.
    push_frame(32'h0, 5, 3, 5, 0, -1, 99);
    @(negedge clk);
    sent_frame_vld = 1'b1;
    sent_frame_data = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    sent_frame_vld = 1'b0;
    @(posedge clk); #1; check("latency_e1", sent, 1);
    @(posedge clk); #1; check("latency_e2", sent, 1);
    @(posedge clk); #1; check("latency_e3", sent, 0);
    check("busy_in_sync", busy, 1);
    wait_done("frame_default", 5000);
    check("idle_sent", sent, 1);
    check("idle_busy", busy, 0);

    // Legacy CRC gives 15; a later config for channel 4 must be ignored.
    cfg(8'd3, 3, 5, 0, 12, 0);
    cfg(8'd4, 10, 9, 0, 12, 1);
    push_frame(32'h0, 15, 3, 5, 0, -1, 99);
    wr(32'h0);
    wait_done("frame_crc_legacy", 5000);

    // Clamps: ctick 1->3, ltick 20->11, fixed pause 5->12; CRC of 5/123456 is 2.
    cfg(8'd3, 1, 20, 1, 5, 1);
    push_frame(32'h05123456, 2, 3, 11, 12, -1, 99);
    wr(32'h05123456);
    wait_done("frame_clamped", 5000);

    // Constant frame length 400 -> 248 pause ticks; 100 -> minimum 12.
    cfg(8'd3, 3, 5, 2, 400, 1);
    push_frame(32'h0, 5, 3, 5, 248, -1, 99);
    wr(32'h0);
    wait_done("frame_const_400", 8000);
    cfg(8'd3, 3, 5, 2, 100, 1);
    push_frame(32'h0, 5, 3, 5, 12, -1, 99);
    wr(32'h0);
    wait_done("frame_const_100", 5000);

    // Config mid-frame only affects the next frame; mismatched channel ignored.
    cfg(8'd3, 3, 5, 0, 12, 1);
    push_frame(32'h0, 5, 3, 5, 0, -1, 99);
    push_frame(32'h05123456, 2, 10, 5, 0, 0, 99);
    wr(32'h0);
    wr(32'h05123456);
    repeat (300) @(negedge clk);
    cfg(8'd3, 10, 5, 0, 12, 1);
    cfg(8'd9, 50, 5, 0, 12, 1);
    wait_done("frame_midcfg", 20000);

    // Five writes into a 4-deep FIFO: one drop, remaining frames back-to-back.
    cfg(8'd3, 3, 5, 0, 12, 1);
    drops = 0;
    push_frame(32'h0, 5, 3, 5, 0, -1, 99);
    push_frame(32'h05123456, 2, 3, 5, 0, 0, 99);
    push_frame(32'hFAFFFFFF, 10, 3, 5, 0, 0, 99);
    push_frame(32'h0, 5, 3, 5, 0, 0, 99);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sent_frame_vld = 1'b1;
      sent_frame_data = ov[i];
      @(negedge clk);
    end
    sent_frame_vld = 1'b0;
    check("fifo_full_after_burst", fifo_full, 1);
    wait_done("frame_burst", 12000);
    check("drop_count", drops, 1);
    check("fifo_empty_after_burst", fifo_full, 0);

    // Config strobe on the same edge the frame starts applies to that frame.
    push_frame(32'h0, 5, 3, 8, 0, -1, 99);
    @(negedge clk);
    sent_frame_vld = 1'b1;
    sent_frame_data = 32'h0;
    @(negedge clk);
    sent_frame_vld = 1'b0;
    sent_config_vld = 1'b1;
    sent_config_channel = 8'd3;
    sent_ctick_len = 8'd3;
    sent_ltick_len = 8'd8;
    sent_pause_mode = 2'd0;
    sent_pause_len = 16'd12;
    sent_crc_mode = 1'b1;
    @(negedge clk);
    sent_config_vld = 1'b0;
    wait_done("frame_cfg_at_start", 5000);

    // Reset during D2's low phase: sync, status, D1 complete; nothing afterwards.
    push_frame(32'h0, 5, 3, 8, 0, -1, 3);
    wr(32'h0);
    repeat (490) @(negedge clk);
    check("pre_reset_low", sent, 0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_sent", sent, 1);
    check("reset_mid_busy", busy, 0);
    falls_snap = falls;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    check("no_pulse_after_reset", falls, falls_snap);
    check("scoreboard_drained", q.size(), 0);
    check("idle_after_reset", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
